// File: rtl/if_pc_fetch_pkg.sv
// Shared types and constants for the IF-stage fetch-PC unit.
// Imported by the top and by the redirect latch.
package if_pc_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  localparam int          INST_ADDR_BUS = 64;
  localparam logic [63:0] PC_START_DFLT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/if_redirect_latch.sv
// Trap/branch priority mux plus the pending-redirect register that remembers
// a redirect seen while a fetch is outstanding, until its response is killed.
module if_redirect_latch import if_pc_fetch_pkg::*; #(
  parameter int ADDR_W = INST_ADDR_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_br_valid,
  input  logic [ADDR_W-1:0] i_br_addr,
  input  logic              i_trap_valid,
  input  logic [ADDR_W-1:0] i_trap_addr,
  input  logic              i_set,
  input  logic              i_clear,
  output logic              o_redir_valid,
  output logic [ADDR_W-1:0] o_redir_addr,
  output logic              o_pend_valid,
  output logic [ADDR_W-1:0] o_tgt_addr
);

  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [ADDR_W-1:0] w_redir_addr;
  logic              w_redir_valid;

  // Trap beats branch when both arrive in the same cycle.
  always_comb begin
    w_redir_addr  = '0;
    w_redir_valid = i_trap_valid | i_br_valid;
    if (i_trap_valid) begin
      w_redir_addr = i_trap_addr;
    end else if (i_br_valid) begin
      w_redir_addr = i_br_addr;
    end else begin
      w_redir_addr = '0;
    end
  end

  // Clear wins over set: a killed response consumes the pending target.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
    end else if (i_clear) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
    end else if (i_set && w_redir_valid) begin
      r_pend_valid <= 1'b1;
      r_pend_addr  <= w_redir_addr;
    end else begin
      r_pend_valid <= r_pend_valid;
      r_pend_addr  <= r_pend_addr;
    end
  end

  assign o_redir_valid = w_redir_valid;
  assign o_redir_addr  = w_redir_addr;
  assign o_pend_valid  = r_pend_valid;
  // A redirect arriving this cycle is newer than anything already pending.
  assign o_tgt_addr    = w_redir_valid ? w_redir_addr : r_pend_addr;

endmodule

// File: rtl/if_pc_fetch.sv
// Fetch-PC unit: one outstanding instruction fetch at a time, with branch and
// trap redirects that squash either the in-flight response or the held instruction.
module if_pc_fetch import if_pc_fetch_pkg::*; #(
  parameter int          ADDR_W     = INST_ADDR_BUS,
  parameter int          INST_W     = 32,
  parameter logic [63:0] PC_START   = PC_START_DFLT,
  parameter int          INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              resp_valid,
  input  logic [INST_W-1:0] resp_inst,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_addr
);

  localparam logic [ADDR_W-1:0] LP_PC_START = PC_START[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LP_INC      = ADDR_W'(INST_BYTES);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_out_pc;
  logic [INST_W-1:0] r_out_inst;
  logic              w_set;
  logic              w_clear;
  logic              w_capture;
  logic              w_redir_valid;
  logic [ADDR_W-1:0] w_redir_addr;
  logic              w_pend_valid;
  logic [ADDR_W-1:0] w_tgt_addr;

  if_redirect_latch #(.ADDR_W(ADDR_W)) u_redirect (
    .clk          (clk),
    .rst          (rst),
    .i_br_valid   (br_valid),
    .i_br_addr    (br_addr),
    .i_trap_valid (trap_valid),
    .i_trap_addr  (trap_addr),
    .i_set        (w_set),
    .i_clear      (w_clear),
    .o_redir_valid(w_redir_valid),
    .o_redir_addr (w_redir_addr),
    .o_pend_valid (w_pend_valid),
    .o_tgt_addr   (w_tgt_addr)
  );

  // Next-state and PC update; the PC only moves once the current fetch is resolved.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_set       = 1'b0;
    w_clear     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_set = 1'b1;
        if (req_ready) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          if (w_pend_valid || w_redir_valid) begin
            w_pc_nxt    = w_tgt_addr;
            w_clear     = 1'b1;
            w_state_nxt = S_REQ;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else begin
          w_set = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_redir_valid) begin
          w_pc_nxt    = w_redir_addr;
          w_state_nxt = S_REQ;
        end else if (out_ready) begin
          w_pc_nxt    = r_pc + LP_INC;
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, PC and the instruction presented to decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= LP_PC_START;
      r_out_pc   <= '0;
      r_out_inst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_capture) begin
        r_out_pc   <= r_pc;
        r_out_inst <= resp_inst;
      end else begin
        r_out_pc   <= r_out_pc;
        r_out_inst <= r_out_inst;
      end
    end
  end

  assign req_valid = (r_state == S_REQ);
  assign req_addr  = r_pc;
  assign out_valid = (r_state == S_HOLD);
  assign out_pc    = r_out_pc;
  assign out_inst  = r_out_inst;

endmodule

// File: tb/tb_if_pc_fetch.sv
// Bench for if_pc_fetch: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model, with literal pins on key cycles.
module tb_if_pc_fetch;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic        br_valid;
  logic [63:0] br_addr;
  logic        trap_valid;
  logic [63:0] trap_addr;

  logic        wr_req_valid;
  logic [31:0] wr_req_addr;
  logic        wr_out_valid;
  logic [31:0] wr_out_pc;
  logic [31:0] wr_out_inst;

  if_pc_fetch dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_inst(resp_inst),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
    .br_valid(br_valid), .br_addr(br_addr),
    .trap_valid(trap_valid), .trap_addr(trap_addr)
  );

  // Narrow instance that starts near the top of the address space.
  if_pc_fetch #(.ADDR_W(32), .INST_W(32), .PC_START(64'h0000_0000_FFFF_FFFC), .INST_BYTES(4)) u_wrap (
    .clk(clk), .rst(rst),
    .req_valid(wr_req_valid), .req_addr(wr_req_addr), .req_ready(1'b1),
    .resp_valid(1'b1), .resp_inst(32'h0000_0013),
    .out_valid(wr_out_valid), .out_pc(wr_out_pc), .out_inst(wr_out_inst), .out_ready(1'b1),
    .br_valid(1'b0), .br_addr(32'h0000_0000),
    .trap_valid(1'b0), .trap_addr(32'h0000_0000)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: what the unit is doing, in terms of fetch transactions.
  bit          m_on = 1'b0;
  bit          m_boot;
  bit          m_inflight;
  bit          m_have;
  bit          m_kill;
  logic [63:0] m_kill_tgt;
  logic [63:0] m_pc;
  logic [63:0] m_opc;
  logic [31:0] m_oinst;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } lit_t;
  lit_t lq[$];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Single compare process: model check every cycle, then any queued literal pins.
  always @(negedge clk) begin
    lit_t        e;
    logic [63:0] act;
    if (m_on) begin
      cmp("req_valid", {63'd0, req_valid}, {63'd0, (!m_boot && !m_inflight && !m_have)});
      if (!m_boot && !m_inflight && !m_have) cmp("req_addr", req_addr, m_pc);
      cmp("out_valid", {63'd0, out_valid}, {63'd0, m_have});
      cmp("out_pc", out_pc, m_opc);
      cmp("out_inst", {32'd0, out_inst}, {32'd0, m_oinst});
    end
    while (lq.size() > 0) begin
      e = lq.pop_front();
      case (e.sel)
        0: act = {63'd0, req_valid};
        1: act = req_addr;
        2: act = {63'd0, out_valid};
        3: act = out_pc;
        4: act = {32'd0, out_inst};
        5: act = {32'd0, wr_req_addr};
        6: act = {63'd0, wr_req_valid};
        7: act = {32'd0, wr_out_pc};
        default: act = 64'hx;
      endcase
      cmp(e.name, act, e.exp);
    end
  end

  task automatic pin(input string nm, input int sel, input logic [63:0] v);
    lit_t e;
    e.name = nm;
    e.sel  = sel;
    e.exp  = v;
    lq.push_back(e);
  endtask

  task automatic model_update();
    bit          redir;
    logic [63:0] tgt;
    redir = trap_valid | br_valid;
    tgt   = trap_valid ? trap_addr : br_addr;
    m_on  = 1'b1;
    if (rst) begin
      m_pc = 64'h8000_0000; m_boot = 1'b1; m_inflight = 1'b0; m_have = 1'b0;
      m_kill = 1'b0; m_kill_tgt = 64'd0; m_opc = 64'd0; m_oinst = 32'd0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_have) begin
      if (redir) begin
        m_pc = tgt; m_have = 1'b0;
      end else if (out_ready) begin
        m_pc = m_pc + 64'd4; m_have = 1'b0;
      end
    end else if (m_inflight) begin
      if (resp_valid) begin
        m_inflight = 1'b0;
        if (m_kill || redir) begin
          m_pc = redir ? tgt : m_kill_tgt;
          m_kill = 1'b0;
        end else begin
          m_have = 1'b1; m_opc = m_pc; m_oinst = resp_inst;
        end
      end else if (redir) begin
        m_kill = 1'b1; m_kill_tgt = tgt;
      end
    end else begin
      if (redir) begin
        m_kill = 1'b1; m_kill_tgt = tgt;
      end
      if (req_ready) m_inflight = 1'b1;
    end
  endtask

  task automatic step(input logic rr, input logic rv, input logic [31:0] ri, input logic orr,
                      input logic bv, input logic [63:0] ba, input logic tv, input logic [63:0] ta);
    req_ready = rr; resp_valid = rv; resp_inst = ri; out_ready = orr;
    br_valid = bv; br_addr = ba; trap_valid = tv; trap_addr = ta;
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_step();
    pin("rst_req_valid", 0, 64'd0); pin("rst_out_valid", 2, 64'd0);
    pin("rst_out_pc", 3, 64'd0); pin("rst_out_inst", 4, 64'd0);
    pin("rst_req_addr", 1, 64'h8000_0000);
    idle_step();

    // Reset release and first fetch; the narrow instance runs alongside.
    rst = 1'b0;
    pin("first_req_valid", 0, 64'd1); pin("first_req_addr", 1, 64'h8000_0000);
    pin("wrap_req_valid0", 6, 64'd1); pin("wrap_req_addr0", 5, 64'h0000_0000_FFFF_FFFC);
    idle_step();
    pin("wait_req_valid", 0, 64'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    pin("first_out_valid", 2, 64'd1); pin("first_out_pc", 3, 64'h8000_0000);
    pin("first_out_inst", 4, 64'h0000_0013); pin("wrap_out_pc", 7, 64'h0000_0000_FFFF_FFFC);
    step(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    pin("seq_req_addr", 1, 64'h8000_0004);
    pin("wrap_req_valid1", 6, 64'd1); pin("wrap_req_addr1", 5, 64'h0000_0000_0000_0000);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0);

    // Back-pressure on both sides.
    for (int i = 0; i < 3; i++) begin
      pin("bp_req_addr", 1, 64'h8000_0004); pin("bp_req_valid", 0, 64'd1);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    end
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    for (int i = 0; i < 5; i++) begin
      pin("bp_out_valid", 2, 64'd1); pin("bp_out_pc", 3, 64'h8000_0004);
      pin("bp_out_inst", 4, 64'h0000_0000_AABB_CCDD);
      if (i == 0) step(1'b0, 1'b1, 32'hAABB_CCDD, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
      else        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    end
    pin("bp_next_addr", 1, 64'h8000_0008);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0);

    // Branch while waiting kills the response.
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    pin("wbr_req_valid", 0, 64'd0); pin("wbr_out_valid", 2, 64'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 64'd0);
    pin("wbr_kill_out_valid", 2, 64'd0); pin("wbr_kill_out_inst", 4, 64'h0000_0000_AABB_CCDD);
    pin("wbr_tgt_valid", 0, 64'd1); pin("wbr_tgt_addr", 1, 64'h8000_0100);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);

    // Trap and branch together in HOLD: trap wins, held instruction squashed.
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    pin("hold_out_valid", 2, 64'd1); pin("hold_out_inst", 4, 64'h0000_0000_1234_5678);
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    pin("sim_out_valid", 2, 64'd0); pin("sim_req_valid", 0, 64'd1);
    pin("sim_req_addr", 1, 64'h8000_0800);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 64'h8000_0100, 1'b1, 64'h8000_0800);

    // Branch during the request, then trap while waiting: latest target is used.
    pin("reqbr_addr_stable", 1, 64'h8000_0800);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 64'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b1, 64'h8000_0A00);
    pin("chain_out_valid", 2, 64'd0); pin("chain_req_addr", 1, 64'h8000_0A00);
    step(1'b0, 1'b1, 32'h0000_0011, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);

    // Reset while waiting, then reset while holding.
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    rst = 1'b1;
    pin("rstw_out_valid", 2, 64'd0); pin("rstw_req_valid", 0, 64'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 64'd0);
    rst = 1'b0;
    pin("rstw_req_valid2", 0, 64'd1); pin("rstw_req_addr", 1, 64'h8000_0000);
    idle_step();
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    pin("rsth_out_valid1", 2, 64'd1);
    step(1'b0, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    rst = 1'b1;
    pin("rsth_out_valid", 2, 64'd0); pin("rsth_req_valid", 0, 64'd0);
    pin("rsth_out_pc", 3, 64'd0);
    idle_step();
    rst = 1'b0;
    pin("rsth_req_valid2", 0, 64'd1); pin("rsth_req_addr", 1, 64'h8000_0000);
    idle_step();

    // Randomized traffic; responses only while a fetch is outstanding.
    for (int i = 0; i < 3000; i++) begin
      logic        rv;
      logic [63:0] ba;
      logic [63:0] ta;
      rst = ($urandom_range(0, 199) == 0);
      rv  = m_inflight ? ($urandom_range(0, 2) != 0) : 1'b0;
      ba  = {$urandom, $urandom};
      ta  = {$urandom, $urandom};
      step(1'($urandom_range(0, 1)), rv, $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0), ba, ($urandom_range(0, 14) == 0), ta);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
